montgomery_mul_pipe: RTL
========================

# montgomery_mul_pipe

Parametrised, pipelined Montgomery multiplier for the Kyber NTT datapath. For each lane it computes a·b·2^(−W) mod Q, fully reduced to [0, Q−1]. It takes LANES coefficient pairs per transaction under a valid/ready handshake with a sideband tag, and feeds butterfly and pointwise-multiply stages that need one product per lane per cycle at sustained throughput.

## Interface
- W, default 16: coefficient width; Montgomery radix R = 2^W.
- Q, default 3329: modulus; odd, Q < 2^(W−1).
- QINV, default 62209: Q^(−1) mod 2^W, unsigned W bits. The product Q·QINV ≡ 1 mod 2^W is checked at elaboration and must fail the build if it does not hold.
- LANES, default 1: number of independent multipliers sharing one handshake.
- TAGW, default 4: sideband tag width, carried unchanged alongside the data.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts input this cycle
- in_a  in  LANES·W  lane i at [i·W +: W], signed two's complement
- in_b  in  LANES·W  same packing as in_a, signed
- in_tag  in  TAGW  tag travelling with the transaction
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_res  out  LANES·W  lane results, unsigned, each in [0, Q−1]
- out_tag  out  TAGW  tag of the transaction on out_res
- busy  out  1  OR of all stage valid bits

## Operation
Three-stage pipeline. Each stage holds a valid bit, lane data and the tag.
- S1 registers p = a·b as a signed 2W-bit value per lane.
- S2 registers k = low W bits of (p·QINV), interpreted as signed W bits. It also registers m = k·Q as signed 2W bits, and p.
- S3 computes the following and registers the result:
  - t = (p − m) >>> W, arithmetic shift. The low W bits of p − m are zero by construction, so the shift is exact.
  - out = t + Q if t < 0, else t.
- Input constraint: |a·b| < Q·2^(W−1). Then t lies in (−Q, Q) and out lies in [0, Q−1]. Behaviour outside this range is unspecified; the bench must not drive it.
- Lanes are independent and have no cross-lane interaction. All lanes share the valid bits and the tag.
- Intermediate widths are signed 2W bits minimum. Truncate only at the defined points (k, t).

## Timing
- Global advance signal: adv = ~v3 | out_ready. When adv=1, all stages shift forward together (S1←input, S2←S1, S3←S2). When adv=0, all stages hold.
- in_ready = adv. It is combinational from out_ready and the S3 valid bit; it does not depend on in_valid.
- A transfer happens on a cycle where in_valid & in_ready. Bubbles shift through as valid=0 entries.
- out_valid = v3. out_res and out_tag are the S3 registers. Once out_valid is high, out_res and out_tag stay stable until out_ready.
- Latency:
  - The result appears 3 cycles after the accepting edge, with no stalls.
  - Each cycle with out_valid & ~out_ready adds one cycle of latency to every in-flight item.
- Throughput: 1 transaction per cycle while out_ready is held high.
- Ordering: strictly in order; out_tag order equals accept order.
- Reset (rst=1 at an edge):
  - v1, v2, v3 are cleared and all data and tag registers are zeroed.
  - After that edge: out_valid=0, out_res=0, out_tag=0, busy=0, and in_ready=1 (since v3=0).
  - In-flight transactions are discarded with no output.
  - An input presented in the same cycle that rst is high is dropped.
- Simultaneous accept and emit on the same edge is legal and loses nothing.

## Test plan
- Basic vectors (LANES=1, no stalls):
  - a=1, b=1 → 169.
  - a=2285, b=1 → 1.
  - a=1353, b=1 → 2285.
  - a=0, b=1234 → 0.
  - a=−1, b=1 → 3160.
  - Each result must appear exactly 3 cycles after acceptance, with tags 0..4 in order.
- Back-to-back streaming: 1000 random pairs with |a|,|b| ≤ 3328 on consecutive cycles and out_ready=1 → one result per cycle. Each result must equal the model (a·b·169) mod Q in [0, 3328]; in_ready must never drop.
- Backpressure: hold out_ready=0 for 5 cycles while feeding continuously → exactly 3 items held. in_ready must fall in the same cycle v3 is set, and out_res must stay stable. On release, the output must resume in order with nothing lost or duplicated.
- Bubbles: random in_valid (50%) combined with random out_ready (50%) → the scoreboard must match in order; busy must be 1 exactly while any stage is valid.
- Mid-flight reset: accept 3 items, then assert rst for 1 cycle → out_valid=0 the next cycle and none of the 3 items ever emerge. A new item accepted right after reset must return its correct result at +3 cycles.
- Parametrised build: LANES=4 with in_a lanes {1, 2285, −1, 3328} and b=1 for all → out_res lanes {169, 1, 3160, 3328·169 mod 3329 = 3160}. A build with a wrong QINV must fail elaboration.

Source files
------------

// File: rtl/montgomery_mul_pipe_if.sv
// Purpose: bundles the input and output valid/ready channels of the Montgomery multiplier.
// Latency: none, wires only.
// Backpressure: carries in_ready/out_ready; the multiplier decides stall behaviour.
interface montgomery_mul_pipe_if #(
  parameter int W     = 16,
  parameter int LANES = 1,
  parameter int TAGW  = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   in_a;
  logic [LANES*W-1:0]   in_b;
  logic [TAGW-1:0]      in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_res;
  logic [TAGW-1:0]      out_tag;

  // Multiplier side: consumes operands, produces results.
  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );

  // Producer/consumer side that drives operands and accepts results.
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/montgomery_mul_pipe.sv
// Purpose: per-lane Montgomery product a*b*2^-W mod Q, fully reduced to [0, Q-1].
// Latency: 3 cycles from accept to result edge; +1 for every cycle the output stalls.
// Backpressure: one global advance; a held result freezes every stage and drops in_ready.
module montgomery_mul_pipe #(
  parameter int W     = 16,
  parameter int Q     = 3329,
  parameter int QINV  = 62209,
  parameter int LANES = 1,
  parameter int TAGW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  montgomery_mul_pipe_if.slave  i_bus,
  output logic                  busy
);

  localparam longint unsigned QQINV = longint'(Q) * longint'(QINV);
  localparam longint unsigned RMASK = (64'd1 << W) - 64'd1;

  // A wrong inverse silently produces garbage, so refuse to build with one.
  if ((QQINV & RMASK) != 64'd1) begin : g_bad_qinv
    $error("montgomery_mul_pipe: Q*QINV is not 1 mod 2^W");
  end
  if (longint'(Q) >= (64'd1 << (W - 1))) begin : g_bad_q
    $error("montgomery_mul_pipe: Q must be below 2^(W-1)");
  end

  localparam logic [W-1:0]          QINV_W = W'(QINV);
  localparam logic signed [2*W-1:0] Q_2W   = (2*W)'(Q);
  localparam logic signed [W-1:0]   Q_W    = W'(Q);

  logic                   r_v1, r_v2, r_v3;
  logic [TAGW-1:0]        r_tag1, r_tag2, r_tag3;
  logic signed [2*W-1:0]  r_p1 [LANES];
  logic signed [2*W-1:0]  r_p2 [LANES];
  logic signed [2*W-1:0]  r_m2 [LANES];
  logic [LANES*W-1:0]     r_res3;

  logic                   w_adv;
  logic signed [2*W-1:0]  w_p [LANES];
  logic signed [2*W-1:0]  w_m [LANES];
  logic [LANES*W-1:0]     w_res;

  assign w_adv = ~r_v3 | i_bus.out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [W-1:0]   w_a, w_b, w_k, w_t;
    logic signed [2*W-1:0] w_ax, w_bx, w_kx, w_d;
    logic                  w_unused_lo;

    assign w_a  = i_bus.in_a[g*W +: W];
    assign w_b  = i_bus.in_b[g*W +: W];
    assign w_ax = {{W{w_a[W-1]}}, w_a};
    assign w_bx = {{W{w_b[W-1]}}, w_b};
    assign w_p[g] = w_ax * w_bx;

    // Only the low W bits of p*QINV matter, so a W x W product suffices.
    assign w_k  = r_p1[g][W-1:0] * QINV_W;
    assign w_kx = {{W{w_k[W-1]}}, w_k};
    assign w_m[g] = w_kx * Q_2W;

    // p - m has a zero low half; its high half is t, which fits W signed bits
    // because |t| < Q < 2^(W-1).
    assign w_d         = r_p2[g] - r_m2[g];
    assign w_t         = w_d[2*W-1:W];
    assign w_unused_lo = ^w_d[W-1:0];
    assign w_res[g*W +: W] = w_t[W-1] ? w_t + Q_W : w_t;
  end

  // Valid bits and tags march together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else if (w_adv) begin
      r_v1   <= i_bus.in_valid;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_tag1 <= i_bus.in_tag;
      r_tag2 <= r_tag1;
      r_tag3 <= r_tag2;
    end
  end

  // Lane datapath registers; bubbles carry don't-care data alongside valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_p1[i] <= '0;
        r_p2[i] <= '0;
        r_m2[i] <= '0;
      end
      r_res3 <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < LANES; i++) begin
        r_p1[i] <= w_p[i];
        r_p2[i] <= r_p1[i];
        r_m2[i] <= w_m[i];
      end
      r_res3 <= w_res;
    end
  end

  assign i_bus.in_ready  = w_adv;
  assign i_bus.out_valid = r_v3;
  assign i_bus.out_res   = r_res3;
  assign i_bus.out_tag   = r_tag3;
  assign busy            = r_v1 | r_v2 | r_v3;

endmodule
